// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with registered occupancy and flags,
// sticky overflow/underflow, synchronous flush, and a selectable read mode
// (standard registered read, or first-word-fall-through).
module sync_fifo_param #(
  parameter int unsigned D_WIDTH    = 32'd8,
  parameter int unsigned DEPTH      = 32'd16,
  parameter int unsigned AFULL_LVL  = DEPTH - 32'd2,
  parameter int unsigned AEMPTY_LVL = 32'd2,
  parameter int unsigned FWFT       = 32'd0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [D_WIDTH-1:0]       data_in,
  input  logic                     rd_en,
  output logic [D_WIDTH-1:0]       data_out,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int AWP1 = AW + 1;
  localparam logic [AW:0] AFULL_C  = AWP1'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_C = AWP1'(AEMPTY_LVL);

  // Storage is deliberately left without reset; data_out never exposes it
  // before it is written because reads are gated by the empty flag.
  logic [D_WIDTH-1:0] mem_r [DEPTH];

  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [AW:0]        count_r;
  logic               full_r;
  logic               empty_r;
  logic               afull_r;
  logic               aempty_r;
  logic               overflow_r;
  logic               underflow_r;
  logic [D_WIDTH-1:0] data_out_r;

  logic               wr_acc_s;
  logic               rd_acc_s;
  logic [AW:0]        wr_ptr_nxt_s;
  logic [AW:0]        rd_ptr_nxt_s;
  logic [AW:0]        count_nxt_s;
  logic               full_nxt_s;
  logic               empty_nxt_s;
  logic               afull_nxt_s;
  logic               aempty_nxt_s;
  logic [D_WIDTH-1:0] head_nxt_s;
  logic [D_WIDTH-1:0] dout_nxt_s;

  // Acceptance, next pointers and next-state flags, so flags land on the same edge as the operation
  always_comb begin
    wr_acc_s     = wr_en & ~full_r;
    rd_acc_s     = rd_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_acc_s};
    rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, rd_acc_s};
    count_nxt_s  = wr_ptr_nxt_s - rd_ptr_nxt_s;
    empty_nxt_s  = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s   = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                   (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    afull_nxt_s  = (count_nxt_s >= AFULL_C);
    aempty_nxt_s = (count_nxt_s <= AEMPTY_C);
  end

  // Next head word for fall-through mode; bypass the write data when the slot being written becomes the head
  always_comb begin
    head_nxt_s = '0;
    if (wr_acc_s && (rd_ptr_nxt_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      head_nxt_s = data_in;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Next data_out: fall-through shows the head whenever non-empty, standard mode loads on an accepted read
  always_comb begin
    dout_nxt_s = data_out_r;
    if (FWFT != 32'd0) begin
      if (empty_nxt_s) begin
        dout_nxt_s = '0;
      end else begin
        dout_nxt_s = head_nxt_s;
      end
    end else begin
      if (rd_acc_s) begin
        dout_nxt_s = mem_r[rd_ptr_r[AW-1:0]];
      end else begin
        dout_nxt_s = data_out_r;
      end
    end
  end

  // Storage write port; a flush in the same cycle wins over the write
  always_ff @(posedge clk) begin
    if (wr_acc_s && !clr) begin
      mem_r[wr_ptr_r[AW-1:0]] <= data_in;
    end
  end

  // Pointers, occupancy, flags, sticky errors and read data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      afull_r     <= 1'b0;
      aempty_r    <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      data_out_r  <= '0;
    end else if (clr) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      afull_r     <= 1'b0;
      aempty_r    <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
      data_out_r  <= '0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      full_r      <= full_nxt_s;
      empty_r     <= empty_nxt_s;
      afull_r     <= afull_nxt_s;
      aempty_r    <= aempty_nxt_s;
      overflow_r  <= overflow_r | (wr_en & full_r);
      underflow_r <= underflow_r | (rd_en & empty_r);
      data_out_r  <= dout_nxt_s;
    end
  end

  assign data_out     = data_out_r;
  assign fifo_full    = full_r;
  assign fifo_empty   = empty_r;
  assign almost_full  = afull_r;
  assign almost_empty = aempty_r;
  assign count        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 Parameter D_WIDTH, default 8, SHALL set the data word width in bits.
REQ-003 Parameter DEPTH, default 16, SHALL set the number of storage words; it is a power of two and at least 2.
REQ-004 Parameter AFULL_LVL, default DEPTH-2, SHALL set the almost-full threshold in words.
REQ-005 Parameter AEMPTY_LVL, default 2, SHALL set the almost-empty threshold in words.
REQ-006 Parameter FWFT, default 0, SHALL select the read mode: 0 = standard, 1 = first-word-fall-through.
REQ-007 Port list, where AW = log2(DEPTH):
- clk, input, 1 bit: rising-edge clock.
- rst_n, input, 1 bit: asynchronous active-low reset.
- clr, input, 1 bit: synchronous flush.
- wr_en, input, 1 bit: write request.
- data_in, input, D_WIDTH bits: write data.
- rd_en, input, 1 bit: read request.
- data_out, output, D_WIDTH bits: read data.
- fifo_full, output, 1 bit: no free word.
- fifo_empty, output, 1 bit: no stored word.
- almost_full, output, 1 bit: count >= AFULL_LVL.
- almost_empty, output, 1 bit: count <= AEMPTY_LVL.
- count, output, AW+1 bits: stored-word occupancy.
- overflow, output, 1 bit: sticky flag, write attempted while full.
- underflow, output, 1 bit: sticky flag, read attempted while empty.

Function
REQ-008 Write and read acceptance SHALL follow these rules:
- A write is accepted when wr_en=1 and fifo_full=0.
- A read is accepted when rd_en=1 and fifo_empty=0.
- Rejected requests SHALL NOT change pointers, memory or count.
REQ-009 Write and read pointers SHALL be AW+1 bits wide and SHALL wrap modulo 2*DEPTH. Storage SHALL be addressed by the pointer bits [AW-1:0].
REQ-010 Flag derivation from the pointers SHALL be:
- fifo_empty = 1 when the pointers are equal.
- fifo_full = 1 when the pointer MSBs differ and the bits [AW-1:0] are equal.
REQ-011 count SHALL equal wr_ptr - rd_ptr, modulo 2*DEPTH, and SHALL range from 0 to DEPTH inclusive.
REQ-012 A write and a read accepted in the same cycle SHALL both complete, and count SHALL remain unchanged.
REQ-013 All flags and count SHALL be registered and SHALL update on the same edge as the accepted operation. There SHALL be no extra cycle of flag latency.
REQ-014 With FWFT=0, data_out SHALL be registered:
- It updates to the head word one cycle after an accepted read.
- It holds its value otherwise.
REQ-015 With FWFT=1, data_out SHALL present the head word, with no clock latency, whenever fifo_empty=0; an accepted read advances to the next word at the following edge.
REQ-016 overflow SHALL set on any edge where wr_en=1 and fifo_full=1. underflow SHALL set on any edge where rd_en=1 and fifo_empty=1. Both SHALL hold until clr or reset.
REQ-017 clr=1 SHALL flush the FIFO at the next edge:
- Pointers, count, overflow, underflow and data_out go to 0.
- fifo_empty and almost_empty go to 1; fifo_full and almost_full go to 0.
- clr SHALL take priority over wr_en and rd_en in the same cycle.
REQ-018 The block SHALL accept write and read requests every cycle, with no bubbles, including across pointer wrap-around.

Reset
REQ-019 rst_n=0 SHALL immediately force the following, independent of clk:
- data_out=0 and count=0.
- fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=0.
- overflow=0, underflow=0.
REQ-020 Storage memory SHALL NOT be reset. Its contents SHALL never be visible on data_out before being written.
REQ-021 rst_n deassertion SHALL be synchronised to clk outside this block. The first write SHALL be accepted on the first edge after deassertion.

Verification
REQ-022 Fill/drain (DEPTH=16, FWFT=0): 16 writes of 0x01..0x10, then 16 reads -> the following SHALL hold:
- fifo_full=1 and count=16 after the 16th write.
- data_out = 0x01..0x10 in order, each one cycle after its read.
- fifo_empty=1 after the last read.
REQ-023 Thresholds: with AFULL_LVL=14 and AEMPTY_LVL=2, write 3 words then 11 more -> the following SHALL hold:
- almost_empty falls on the edge where count goes from 2 to 3.
- almost_full rises on the edge where count reaches 14.
REQ-024 Errors: write while full, and read while empty -> the following SHALL hold:
- overflow=1 and underflow=1.
- count, pointers and data_out are unchanged.
- Both flags clear only after a 1-cycle clr.
REQ-025 Simultaneous access: with count=16, drive wr_en=rd_en=1 -> only the read is accepted and count=15. With count=8, the same stimulus for 40 cycles -> count stays 8, pointers wrap, and the data order is preserved.
REQ-026 FWFT=1: write 0xA5 to an empty FIFO -> data_out=0xA5 while fifo_empty=0, before any read; read -> fifo_empty=1.
REQ-027 Mid-operation reset: assert rst_n=0 asynchronously between edges with count=9 -> the following SHALL hold:
- All outputs reach their reset values immediately.
- The first read after release is rejected with underflow=1.
